// File: rtl/ula_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM state type and
// the rule that decides which operations go through the iterative datapath.
package ula_pkg;

    localparam logic [2:0] OP_PASSA = 3'b000;
    localparam logic [2:0] OP_SOMA  = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_E     = 3'b011;
    localparam logic [2:0] OP_OU    = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_DIV   = 3'b110;
    localparam logic [2:0] OP_NAO   = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        CALC   = 2'b01,
        FIM    = 2'b10
    } estado_t;

    // Division by zero is resolved in a single step, so it never enters CALC.
    function automatic logic eh_iterativa(input logic [2:0] op, input logic divisor_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !divisor_zero);
    endfunction

endpackage

// File: rtl/ula_iterativa.sv
// Iterative mul/div datapath: shift-add multiply and restoring divide on
// magnitudes, one step per cycle for LARGURA cycles, with sign correction.
module ula_iterativa #(
    parameter int unsigned LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               modo_div,
    input  logic [LARGURA-1:0] op_a,
    input  logic [LARGURA-1:0] op_b,
    output logic               concluido,
    output logic [LARGURA-1:0] resultado,
    output logic               estouro
);

    localparam int unsigned CONT_W = $clog2(LARGURA);

    logic                  ativo;
    logic                  eh_div;
    logic                  negativo;
    logic [LARGURA-1:0]    acc;
    logic [LARGURA-1:0]    reg_q;
    logic [LARGURA-1:0]    mag_b;
    logic [CONT_W-1:0]     contador;

    logic [LARGURA-1:0]    mag_a_ent;
    logic [LARGURA-1:0]    mag_b_ent;
    logic [LARGURA-1:0]    parcela;
    logic [LARGURA:0]      soma;
    logic [LARGURA:0]      desl;
    logic [LARGURA:0]      dif;
    logic [LARGURA-1:0]    acc_prox;
    logic [LARGURA-1:0]    q_prox;
    logic [2*LARGURA-1:0]  prod;
    logic [2*LARGURA-1:0]  prod_s;
    logic [LARGURA-1:0]    quoc;

    // The magnitude of MIN is 2^(LARGURA-1), which still fits as unsigned.
    assign mag_a_ent = op_a[LARGURA-1] ? -op_a : op_a;
    assign mag_b_ent = op_b[LARGURA-1] ? -op_b : op_b;

    assign concluido = ativo && (contador == CONT_W'(LARGURA - 1));

    always_comb begin
        parcela = reg_q[0] ? mag_b : '0;
        soma    = {1'b0, acc} + {1'b0, parcela};
        desl    = {acc, reg_q[LARGURA-1]};
        dif     = desl - {1'b0, mag_b};

        if (eh_div) begin
            if (!dif[LARGURA]) begin
                acc_prox = dif[LARGURA-1:0];
                q_prox   = {reg_q[LARGURA-2:0], 1'b1};
            end else begin
                acc_prox = desl[LARGURA-1:0];
                q_prox   = {reg_q[LARGURA-2:0], 1'b0};
            end
        end else begin
            acc_prox = soma[LARGURA:1];
            q_prox   = {soma[0], reg_q[LARGURA-1:1]};
        end

        // Result is taken from the next-state values so it is ready on the last step.
        prod   = {acc_prox, q_prox};
        prod_s = negativo ? -prod : prod;
        quoc   = negativo ? -q_prox : q_prox;

        if (eh_div) begin
            resultado = quoc;
            estouro   = !negativo && q_prox[LARGURA-1];
        end else begin
            resultado = prod_s[LARGURA-1:0];
            estouro   = !((&prod_s[2*LARGURA-1:LARGURA-1]) ||
                          !(|prod_s[2*LARGURA-1:LARGURA-1]));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ativo    <= 1'b0;
            eh_div   <= 1'b0;
            negativo <= 1'b0;
            acc      <= '0;
            reg_q    <= '0;
            mag_b    <= '0;
            contador <= '0;
        end else if (iniciar) begin
            ativo    <= 1'b1;
            eh_div   <= modo_div;
            negativo <= op_a[LARGURA-1] ^ op_b[LARGURA-1];
            acc      <= '0;
            reg_q    <= mag_a_ent;
            mag_b    <= mag_b_ent;
            contador <= '0;
        end else if (ativo) begin
            acc   <= acc_prox;
            reg_q <= q_prox;
            if (concluido) begin
                ativo    <= 1'b0;
                contador <= '0;
            end else begin
                contador <= contador + CONT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-step ops complete in one cycle, mul/div are handed
// to ula_iterativa; results and flags are registered on entry to FIM.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int unsigned LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    input  logic [2:0]         selecao,
    input  logic [LARGURA-1:0] var_X,
    input  logic [LARGURA-1:0] var_Y,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] resultado,
    output logic               flag_N,
    output logic               flag_Z,
    output logic               flag_C,
    output logic               flag_V,
    output logic               erro_div0
);

    estado_t estado;

    logic               divisor_zero;
    logic               usa_iter;
    logic               iniciar_iter;
    logic               iter_concluido;
    logic [LARGURA-1:0] res_iter;
    logic               estouro_iter;

    logic [LARGURA:0]   soma_ext;
    logic [LARGURA:0]   sub_ext;
    logic [LARGURA-1:0] res_imed;
    logic               c_imed;
    logic               v_imed;
    logic               e_imed;

    assign divisor_zero = (var_Y == '0);
    assign usa_iter     = eh_iterativa(selecao, divisor_zero);
    assign iniciar_iter = (estado == OCIOSO) && inicio && usa_iter;

    always_comb begin
        soma_ext = {1'b0, var_X} + {1'b0, var_Y};
        sub_ext  = {1'b0, var_X} - {1'b0, var_Y};
        res_imed = '0;
        c_imed   = 1'b0;
        v_imed   = 1'b0;
        e_imed   = 1'b0;
        case (selecao)
            OP_PASSA: res_imed = var_X;
            OP_SOMA: begin
                res_imed = soma_ext[LARGURA-1:0];
                c_imed   = soma_ext[LARGURA];
                v_imed   = (var_X[LARGURA-1] == var_Y[LARGURA-1]) &&
                           (res_imed[LARGURA-1] != var_X[LARGURA-1]);
            end
            OP_SUB: begin
                res_imed = sub_ext[LARGURA-1:0];
                // Top bit of the widened difference is the unsigned borrow.
                c_imed   = sub_ext[LARGURA];
                v_imed   = (var_X[LARGURA-1] != var_Y[LARGURA-1]) &&
                           (res_imed[LARGURA-1] != var_X[LARGURA-1]);
            end
            OP_E:   res_imed = var_X & var_Y;
            OP_OU:  res_imed = var_X | var_Y;
            OP_NAO: res_imed = ~var_X;
            OP_DIV: begin
                res_imed = '1;
                e_imed   = 1'b1;
            end
            default: res_imed = '0;
        endcase
    end

    ula_iterativa #(
        .LARGURA (LARGURA)
    ) u_iterativa (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar_iter),
        .modo_div  (selecao == OP_DIV),
        .op_a      (var_X),
        .op_b      (var_Y),
        .concluido (iter_concluido),
        .resultado (res_iter),
        .estouro   (estouro_iter)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            resultado <= '0;
            flag_N    <= 1'b0;
            flag_Z    <= 1'b1;
            flag_C    <= 1'b0;
            flag_V    <= 1'b0;
            erro_div0 <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    pronto <= 1'b0;
                    if (inicio) begin
                        ocupado <= 1'b1;
                        if (usa_iter) begin
                            estado <= CALC;
                        end else begin
                            estado    <= FIM;
                            pronto    <= 1'b1;
                            resultado <= res_imed;
                            flag_N    <= res_imed[LARGURA-1];
                            flag_Z    <= (res_imed == '0);
                            flag_C    <= c_imed;
                            flag_V    <= v_imed;
                            erro_div0 <= e_imed;
                        end
                    end
                end
                CALC: begin
                    if (iter_concluido) begin
                        estado    <= FIM;
                        pronto    <= 1'b1;
                        resultado <= res_iter;
                        flag_N    <= res_iter[LARGURA-1];
                        flag_Z    <= (res_iter == '0);
                        flag_C    <= 1'b0;
                        flag_V    <= estouro_iter;
                        erro_div0 <= 1'b0;
                    end
                end
                FIM: begin
                    estado  <= OCIOSO;
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                end
                default: begin
                    estado  <= OCIOSO;
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo at widths 32 and 8, checked against an
// arithmetic reference model of the ALU operations.
module tb_ula_multiciclo;
    import ula_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
        logic        e;
    } saida_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ini32, ocu32, pr32, n32, z32, c32, v32, e32;
    logic [2:0]  sel32;
    logic [31:0] x32, y32, res32;

    logic        ini8, ocu8, pr8, n8, z8, c8, v8, e8;
    logic [2:0]  sel8;
    logic [7:0]  x8, y8, res8;

    int tests  = 0;
    int falhas = 0;

    ula_multiciclo #(.LARGURA(32)) dut32 (
        .clock(clk), .reset(rst), .inicio(ini32), .selecao(sel32),
        .var_X(x32), .var_Y(y32), .ocupado(ocu32), .pronto(pr32), .resultado(res32),
        .flag_N(n32), .flag_Z(z32), .flag_C(c32), .flag_V(v32), .erro_div0(e32)
    );

    ula_multiciclo #(.LARGURA(8)) dut8 (
        .clock(clk), .reset(rst), .inicio(ini8), .selecao(sel8),
        .var_X(x8), .var_Y(y8), .ocupado(ocu8), .pronto(pr8), .resultado(res8),
        .flag_N(n8), .flag_Z(z8), .flag_C(c8), .flag_V(v8), .erro_div0(e8)
    );

    // Reference model: plain signed/unsigned arithmetic on 64-bit integers.
    function automatic saida_t modelo(input int w, input logic [2:0] op,
                                      input logic [31:0] x, input logic [31:0] y);
        longint um   = 1;
        longint modv = um << w;
        longint mask = modv - 1;
        longint half = um << (w - 1);
        longint ux   = longint'(x) & mask;
        longint uy   = longint'(y) & mask;
        longint sx   = (ux >= half) ? ux - modv : ux;
        longint sy   = (uy >= half) ? uy - modv : uy;
        longint full = 0;
        longint rm;
        saida_t r    = '0;
        case (op)
            OP_PASSA: full = sx;
            OP_SOMA: begin
                full = sx + sy;
                r.c  = (ux + uy) >= modv;
                r.v  = (full >= half) || (full < -half);
            end
            OP_SUB: begin
                full = sx - sy;
                r.c  = ux < uy;
                r.v  = (full >= half) || (full < -half);
            end
            OP_E:   full = ux & uy;
            OP_OU:  full = ux | uy;
            OP_NAO: full = ~ux;
            OP_MUL: begin
                full = sx * sy;
                r.v  = (full >= half) || (full < -half);
            end
            default: begin
                if (uy == 0) begin
                    full = -1;
                    r.e  = 1'b1;
                end else if (sx == -half && sy == -1) begin
                    full = -half;
                    r.v  = 1'b1;
                end else begin
                    full = sx / sy;
                end
            end
        endcase
        rm    = full & mask;
        r.res = 32'(rm);
        r.n   = ((rm >> (w - 1)) & 1) != 0;
        r.z   = (rm == 0);
        return r;
    endfunction

    function automatic int lat_esp(input int w, input logic [2:0] op, input logic [31:0] y);
        logic [31:0] ym;
        ym = (w == 8) ? {24'd0, y[7:0]} : y;
        return (op == OP_MUL || (op == OP_DIV && ym != 0)) ? w + 1 : 1;
    endfunction

    // Drives one request on an idle DUT and waits (bounded) for pronto.
    task automatic opera(input bit d8, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, output saida_t obs, output int lat);
        @(negedge clk);
        if (d8) begin
            sel8 = op; x8 = x[7:0]; y8 = y[7:0]; ini8 = 1'b1;
        end else begin
            sel32 = op; x32 = x; y32 = y; ini32 = 1'b1;
        end
        @(negedge clk);
        ini8  = 1'b0;
        ini32 = 1'b0;
        lat   = 1;
        while (!(d8 ? pr8 : pr32) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (d8) obs = {24'd0, res8, n8, z8, c8, v8, e8};
        else    obs = {res32, n32, z32, c32, v32, e32};
    endtask

    task automatic test_reset();
        saida_t esp, o32, o8;
        esp   = '0;
        esp.z = 1'b1;
        for (int k = 0; k < 2; k++) begin
            o32 = {res32, n32, z32, c32, v32, e32};
            o8  = {24'd0, res8, n8, z8, c8, v8, e8};
            tests++;
            if (o32 !== esp || ocu32 !== 1'b0 || pr32 !== 1'b0) begin
                falhas++;
                $display("FAIL reset32[%0d]: got %h ocu=%b pr=%b, want %h ocu=0 pr=0",
                         k, o32, ocu32, pr32, esp);
            end
            tests++;
            if (o8 !== esp || ocu8 !== 1'b0 || pr8 !== 1'b0) begin
                falhas++;
                $display("FAIL reset8[%0d]: got %h ocu=%b pr=%b, want %h ocu=0 pr=0",
                         k, o8, ocu8, pr8, esp);
            end
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_dirigido();
        logic [2:0]  op  [12];
        logic [31:0] xa  [12];
        logic [31:0] ya  [12];
        logic [31:0] ra  [12];
        saida_t obs, esp;
        int lat;
        op[0]  = OP_SOMA;  xa[0]  = 32'h7FFF_FFFF; ya[0]  = 32'h1;         ra[0]  = 32'h8000_0000;
        op[1]  = OP_SUB;   xa[1]  = 32'd5;         ya[1]  = 32'd5;         ra[1]  = 32'h0;
        op[2]  = OP_SUB;   xa[2]  = 32'd3;         ya[2]  = 32'd5;         ra[2]  = 32'hFFFF_FFFE;
        op[3]  = OP_MUL;   xa[3]  = 32'hFFFF_FFF9; ya[3]  = 32'd6;         ra[3]  = 32'hFFFF_FFD6;
        op[4]  = OP_MUL;   xa[4]  = 32'h0001_0000; ya[4]  = 32'h0001_0000; ra[4]  = 32'h0;
        op[5]  = OP_DIV;   xa[5]  = 32'hFFFF_FFF9; ya[5]  = 32'd2;         ra[5]  = 32'hFFFF_FFFD;
        op[6]  = OP_DIV;   xa[6]  = 32'h8000_0000; ya[6]  = 32'hFFFF_FFFF; ra[6]  = 32'h8000_0000;
        op[7]  = OP_DIV;   xa[7]  = 32'd9;         ya[7]  = 32'd0;         ra[7]  = 32'hFFFF_FFFF;
        op[8]  = OP_E;     xa[8]  = 32'hF0F0_F0F0; ya[8]  = 32'hFF00_FF00; ra[8]  = 32'hF000_F000;
        op[9]  = OP_OU;    xa[9]  = 32'hF0F0_F0F0; ya[9]  = 32'hFF00_FF00; ra[9]  = 32'hFFF0_FFF0;
        op[10] = OP_NAO;   xa[10] = 32'h0;         ya[10] = 32'h1234;      ra[10] = 32'hFFFF_FFFF;
        op[11] = OP_PASSA; xa[11] = 32'h1234_5678; ya[11] = 32'h0;         ra[11] = 32'h1234_5678;
        for (int i = 0; i < 12; i++) begin
            opera(1'b0, op[i], xa[i], ya[i], obs, lat);
            esp = modelo(32, op[i], xa[i], ya[i]);
            tests++;
            if (obs.res !== ra[i]) begin
                falhas++;
                $display("FAIL dir_res[%0d]: got %h want %h", i, obs.res, ra[i]);
            end
            tests++;
            if (obs !== esp) begin
                falhas++;
                $display("FAIL dir_flags[%0d]: got %h want %h", i, obs, esp);
            end
            tests++;
            if (lat != lat_esp(32, op[i], ya[i])) begin
                falhas++;
                $display("FAIL dir_lat[%0d]: got %0d want %0d", i, lat, lat_esp(32, op[i], ya[i]));
            end
        end
    endtask

    task automatic test_aleatorio();
        logic [2:0]  op;
        logic [31:0] x, y;
        saida_t obs, esp;
        int lat;
        for (int i = 0; i < 50; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(0, 15));
                3: begin x = 32'($urandom_range(0, 60000)) - 32'd30000; y = $urandom & 32'h0000_FFFF; end
                default: y = $urandom;
            endcase
            opera(1'b0, op, x, y, obs, lat);
            esp = modelo(32, op, x, y);
            tests++;
            if (obs !== esp || lat != lat_esp(32, op, y)) begin
                falhas++;
                $display("FAIL rand32[%0d] op=%0d x=%h y=%h: got %h lat %0d want %h lat %0d",
                         i, op, x, y, obs, lat, esp, lat_esp(32, op, y));
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulsos = 0;
        int duplos = 0;
        logic ant  = 1'b0;
        @(negedge clk);
        sel32 = OP_SOMA; x32 = 32'd1; y32 = 32'd2; ini32 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (pr32) pulsos++;
            if (pr32 && ant) duplos++;
            ant = pr32;
        end
        ini32 = 1'b0;
        tests++;
        if (pulsos != 4 || duplos != 0) begin
            falhas++;
            $display("FAIL back_to_back: got %0d pulses (%0d adjacent), want 4 (0)", pulsos, duplos);
        end
        tests++;
        if (res32 !== 32'd3) begin
            falhas++;
            $display("FAIL b2b_res: got %h want 00000003", res32);
        end
    endtask

    task automatic test_ignora();
        logic [31:0] x, y;
        saida_t obs, esp;
        int lat;
        x = 32'($urandom_range(0, 2000)) - 32'd1000;
        y = 32'($urandom_range(0, 2000)) - 32'd1000;
        @(negedge clk);
        sel32 = OP_MUL; x32 = x; y32 = y; ini32 = 1'b1;
        @(negedge clk);
        ini32 = 1'b0;
        lat   = 1;
        while (!pr32 && lat < 200) begin
            if (lat == 10) begin
                ini32 = 1'b1; sel32 = OP_SOMA; x32 = 32'd99; y32 = 32'd77;
            end else begin
                ini32 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        ini32 = 1'b0;
        obs = {res32, n32, z32, c32, v32, e32};
        esp = modelo(32, OP_MUL, x, y);
        tests++;
        if (obs !== esp || lat != 33) begin
            falhas++;
            $display("FAIL ignore_busy: got %h lat %0d want %h lat 33", obs, lat, esp);
        end
    endtask

    task automatic test_reset_meio();
        saida_t esp, obs;
        int vistos = 0;
        esp   = '0;
        esp.z = 1'b1;
        @(negedge clk);
        sel32 = OP_DIV; x32 = 32'd1000; y32 = 32'd7; ini32 = 1'b1;
        @(negedge clk);
        ini32 = 1'b0;
        repeat (19) @(negedge clk);
        #1 rst = 1'b1;
        #2;
        obs = {res32, n32, z32, c32, v32, e32};
        tests++;
        if (obs !== esp || ocu32 !== 1'b0 || pr32 !== 1'b0) begin
            falhas++;
            $display("FAIL reset_mid: got %h ocu=%b pr=%b want %h ocu=0 pr=0",
                     obs, ocu32, pr32, esp);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (pr32) vistos++;
        end
        tests++;
        if (vistos != 0) begin
            falhas++;
            $display("FAIL reset_abort: got %0d pronto pulses want 0", vistos);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; sel32 = OP_SOMA; x32 = 32'd2; y32 = 32'd2; ini32 = 1'b1;
        @(negedge clk);
        ini32 = 1'b0;
        tests++;
        if (pr32 !== 1'b1 || res32 !== 32'd4) begin
            falhas++;
            $display("FAIL first_after_reset: got pr=%b res=%h want pr=1 res=00000004", pr32, res32);
        end
    endtask

    task automatic test_largura8();
        logic [2:0]  op;
        logic [31:0] x, y;
        saida_t obs, esp;
        int lat;
        opera(1'b1, OP_DIV, 32'h80, 32'h03, obs, lat);
        tests++;
        if (obs.res !== 32'h0000_00D6 || lat != 9) begin
            falhas++;
            $display("FAIL w8_div: got %h lat %0d want 000000d6 lat 9", obs.res, lat);
        end
        opera(1'b1, OP_MUL, 32'h10, 32'h08, obs, lat);
        tests++;
        if (obs.res !== 32'h0000_0080 || obs.v !== 1'b1 || lat != 9) begin
            falhas++;
            $display("FAIL w8_mul: got %h v=%b lat %0d want 00000080 v=1 lat 9",
                     obs.res, obs.v, lat);
        end
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = 32'($urandom_range(0, 255));
            y  = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom_range(0, 255));
            if (i % 10 == 3) begin
                x = 32'h80; y = 32'hFF;
            end
            opera(1'b1, op, x, y, obs, lat);
            esp = modelo(8, op, x, y);
            tests++;
            if (obs !== esp || lat != lat_esp(8, op, y)) begin
                falhas++;
                $display("FAIL rand8[%0d] op=%0d x=%h y=%h: got %h lat %0d want %h lat %0d",
                         i, op, x[7:0], y[7:0], obs, lat, esp, lat_esp(8, op, y));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        ini32 = 1'b0; sel32 = '0; x32 = '0; y32 = '0;
        ini8  = 1'b0; sel8  = '0; x8  = '0; y8  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_dirigido();
        test_aleatorio();
        test_back_to_back();
        test_ignora();
        test_reset_meio();
        test_largura8();
        $display("[TB] %0d tests run, %0d failed", tests, falhas);
        $finish;
    end

endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 Parameter LARGURA, default 32: operand and result width in bits, minimum 8.
REQ-002 Ports are listed below as name, direction, width, meaning, one per line.
REQ-003 clock  in  1  single system clock; all registers update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 inicio  in  1  operation request; accepted only when ocupado=0.
REQ-006 selecao  in  3  opcode: 000 pass X, 001 add, 010 sub, 011 and, 100 or, 101 mul, 110 div, 111 not X.
REQ-007 var_X, var_Y  in  LARGURA  signed two's-complement operands, sampled on acceptance only.
REQ-008 ocupado  out  1  high while an operation is in progress.
REQ-009 pronto  out  1  single-cycle pulse marking a new valid resultado and flag set.
REQ-010 resultado  out  LARGURA  signed result, held until the next completion.
REQ-011 flag_N, flag_Z, flag_C, flag_V, erro_div0  out  1 each  negative, zero, carry/borrow, signed overflow, divide-by-zero flags, held with resultado.

Function
REQ-012 Acceptance occurs at a rising edge where inicio=1 and ocupado=0; selecao, var_X and var_Y are latched at that edge.
REQ-013 inicio while ocupado=1 is ignored, with no queuing and no effect on the running operation.
REQ-014 FSM states are OCIOSO, CALC and FIM: OCIOSO->FIM on acceptance of opcodes 000/001/010/011/100/111 or of div with var_Y=0; OCIOSO->CALC on acceptance of mul/div otherwise; CALC->FIM when the iteration counter reaches LARGURA-1; FIM->OCIOSO unconditionally.
REQ-015 pronto=1 exactly in state FIM; ocupado=1 in CALC and FIM.
REQ-016 Latency, measured from the acceptance edge to the edge after which pronto=1: 1 cycle for single-step ops and div-by-zero; LARGURA+1 cycles for mul/div.
REQ-017 Back-to-back: a new acceptance is possible at the edge leaving FIM+1, i.e. the first edge with ocupado=0, giving throughput of one single-step op per 2 cycles.
REQ-018 Add/sub: resultado is modulo 2^LARGURA; flag_C is the unsigned carry-out (add) or borrow, X<Y unsigned (sub); flag_V is signed overflow.
REQ-019 Mul: iterative shift-add over LARGURA steps on magnitudes with sign correction; resultado is the low LARGURA bits of the signed product; flag_V=1 if the full signed product does not fit LARGURA bits; flag_C=0.
REQ-020 Div: iterative restoring division over LARGURA steps, quotient truncated toward zero, remainder discarded.
REQ-021 Div MIN/-1: resultado=MIN (100...0), flag_V=1.
REQ-022 Div by zero: resultado=all ones, erro_div0=1, flag_V=0, flag_C=0.
REQ-023 erro_div0=0 for all other completions.
REQ-024 Logic, pass and not ops: flag_C=0, flag_V=0.
REQ-025 flag_Z=1 iff resultado==0, and flag_N=resultado[LARGURA-1], for every completion.
REQ-026 Outputs change only at the edge entering FIM; between completions they hold their values.

Reset
REQ-027 reset=1 forces, immediately and independent of clock, state OCIOSO, iteration counter 0, ocupado=0, pronto=0, resultado=0, flag_Z=1, and flag_N, flag_C, flag_V and erro_div0 all 0.
REQ-028 Reset during CALC or FIM aborts the operation with no pronto pulse; the first acceptance is possible at the first rising edge after reset deasserts.

Structure
REQ-029 Shared package ula_pkg holds the opcode constants (OP_PASSA, OP_SOMA, OP_SUB, OP_E, OP_OU, OP_MUL, OP_DIV, OP_NAO) and the FSM state type.
REQ-030 Sub-module ula_iterativa contains the mul/div datapath (accumulator, shift registers, counter), with start/done handshake to the top FSM.
REQ-031 LARGURA propagates to ula_iterativa; no width is hard-coded.

Verification
REQ-032 LARGURA=32, add 0x7FFFFFFF+1 -> pronto 1 cycle after acceptance, resultado=0x80000000, N=1, V=1, C=0, Z=0.
REQ-033 Sub 5-5 -> resultado=0, Z=1, C=0; sub 3-5 -> resultado=-2, N=1, C=1.
REQ-034 Mul -7*6 -> pronto exactly 33 cycles after acceptance, resultado=-42, V=0; mul 0x10000*0x10000 -> resultado=0, Z=1, V=1.
REQ-035 Div -7/2 -> resultado=-3 after 33 cycles; div 0x80000000/-1 -> resultado=0x80000000, V=1; div 9/0 -> resultado=0xFFFFFFFF, erro_div0=1, latency 1.
REQ-036 Mul accepted, inicio pulsed with new operands at cycle 10 -> request ignored, original product delivered; reset asserted at cycle 20 of a div -> ocupado=0, no pronto, outputs at reset values.
REQ-037 LARGURA=8 regression: div -128/3 -> resultado=-42 after 9 cycles; mul 16*8 -> resultado=-128, V=1.
